// File: rtl/serial_nibble_subtractor.sv
// -----------------------------------------------------------------------------
// serial_nibble_subtractor
//
// Multi-cycle subtractor computing D = A - B - BIN one NIBBLE-wide slice per
// clock, least significant slice first. Produces the difference modulo
// 2^WIDTH, the unsigned borrow-out and the two's-complement overflow flag.
// Operands arrive on a valid/ready handshake; the result leaves on another.
//
// Sequencing: IDLE (accept operands) -> CALC (STEPS slices) -> DONE (hold the
// result until the consumer takes it) -> IDLE.
// -----------------------------------------------------------------------------
module serial_nibble_subtractor #(
    parameter int WIDTH  = 8,
    parameter int NIBBLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int STEPS  = WIDTH / NIBBLE;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [STEP_W-1:0] STEP_ZERO = STEP_W'(0);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    // -------------------------------------------------------------------------
    // Sequencer states
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // Slice arithmetic: {borrow_out, diff} = a - b - borrow_in, evaluated in
    // NIBBLE+1 bits so the top bit of the result is exactly the slice borrow.
    // -------------------------------------------------------------------------
    function automatic logic [NIBBLE:0] nibble_sub(
        input logic [NIBBLE-1:0] x,
        input logic [NIBBLE-1:0] y,
        input logic              brw_in
    );
        logic [NIBBLE:0] xe;
        logic [NIBBLE:0] ye;
        logic [NIBBLE:0] be;
        xe = {1'b0, x};
        ye = {1'b0, y};
        be = {{NIBBLE{1'b0}}, brw_in};
        return xe - ye - be;
    endfunction

    // Signed overflow of a subtraction: operands of differing sign and a result
    // whose sign differs from the minuend.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              borrow_r;
    logic [STEP_W-1:0] step_r;
    logic [WIDTH-1:0]  d_r;
    logic              bout_r;
    logic              ovf_r;
    logic              in_ready_r;
    logic              out_valid_r;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    logic [1:0]        state_n_s;
    logic [WIDTH-1:0]  a_n_s;
    logic [WIDTH-1:0]  b_n_s;
    logic              borrow_n_s;
    logic [STEP_W-1:0] step_n_s;
    logic [WIDTH-1:0]  d_n_s;
    logic              bout_n_s;
    logic              ovf_n_s;
    logic              in_ready_n_s;
    logic              out_valid_n_s;

    // Current slice operands and slice result
    logic [NIBBLE-1:0] slice_a_s;
    logic [NIBBLE-1:0] slice_b_s;
    logic [NIBBLE:0]   slice_res_s;
    logic [NIBBLE-1:0] slice_diff_s;
    logic              slice_brw_s;
    logic              last_step_s;

    // Select the slice addressed by the step counter and subtract it.
    always_comb begin
        slice_a_s    = a_r[step_r*NIBBLE +: NIBBLE];
        slice_b_s    = b_r[step_r*NIBBLE +: NIBBLE];
        slice_res_s  = nibble_sub(slice_a_s, slice_b_s, borrow_r);
        slice_diff_s = slice_res_s[NIBBLE-1:0];
        slice_brw_s  = slice_res_s[NIBBLE];
        last_step_s  = (step_r == STEP_LAST);
    end

    // Sequencer: decide the next value of every register from the current state.
    always_comb begin
        state_n_s     = state_r;
        a_n_s         = a_r;
        b_n_s         = b_r;
        borrow_n_s    = borrow_r;
        step_n_s      = step_r;
        d_n_s         = d_r;
        bout_n_s      = bout_r;
        ovf_n_s       = ovf_r;
        in_ready_n_s  = in_ready_r;
        out_valid_n_s = out_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    // Capture operands; bin only ever enters slice 0.
                    a_n_s         = a;
                    b_n_s         = b;
                    borrow_n_s    = bin;
                    step_n_s      = STEP_ZERO;
                    state_n_s     = ST_CALC;
                    in_ready_n_s  = 1'b0;
                    out_valid_n_s = 1'b0;
                end else begin
                    in_ready_n_s  = 1'b1;
                    out_valid_n_s = 1'b0;
                end
            end

            ST_CALC: begin
                d_n_s[step_r*NIBBLE +: NIBBLE] = slice_diff_s;
                borrow_n_s                     = slice_brw_s;
                if (last_step_s) begin
                    // The final slice holds the result MSB, so the overflow
                    // flag can be formed from this cycle's slice difference.
                    bout_n_s      = slice_brw_s;
                    ovf_n_s       = sub_overflow(a_r[WIDTH-1], b_r[WIDTH-1],
                                                 slice_diff_s[NIBBLE-1]);
                    state_n_s     = ST_DONE;
                    out_valid_n_s = 1'b1;
                end else begin
                    step_n_s      = step_r + STEP_ONE;
                    out_valid_n_s = 1'b0;
                end
                in_ready_n_s = 1'b0;
            end

            ST_DONE: begin
                if (out_ready) begin
                    // Result stays on d/bout/ovf; only the valid flag drops.
                    state_n_s     = ST_IDLE;
                    out_valid_n_s = 1'b0;
                    in_ready_n_s  = 1'b1;
                end else begin
                    out_valid_n_s = 1'b1;
                    in_ready_n_s  = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_n_s     = ST_IDLE;
                borrow_n_s    = 1'b0;
                step_n_s      = STEP_ZERO;
                in_ready_n_s  = 1'b1;
                out_valid_n_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            borrow_r    <= 1'b0;
            step_r      <= STEP_ZERO;
            d_r         <= {WIDTH{1'b0}};
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            a_r         <= a_n_s;
            b_r         <= b_n_s;
            borrow_r    <= borrow_n_s;
            step_r      <= step_n_s;
            d_r         <= d_n_s;
            bout_r      <= bout_n_s;
            ovf_r       <= ovf_n_s;
            in_ready_r  <= in_ready_n_s;
            out_valid_r <= out_valid_n_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from registers.
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign d         = d_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for serial_nibble_subtractor (WIDTH=8, NIBBLE=4).
// A transaction-level model predicts handshake flags and results from plain
// integer arithmetic; a compare process checks the DUT against it on every
// falling edge, and directed vectors pin both DUT and model to literals.
// -----------------------------------------------------------------------------
module tb_serial_nibble_subtractor;

    localparam int W     = 8;
    localparam int STEPS = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errs   = 0;

    serial_nibble_subtractor #(.WIDTH(8), .NIBBLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison helper: counts every check and reports mismatches.
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the definition of a - b - bin.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        int ud;
        int sd;
        logic [W-1:0] dd;
        ud = int'(x) - int'(y) - int'(c);
        sd = int'($signed(x)) - int'($signed(y)) - int'(c);
        dd = W'(ud & 255);
        return {(sd < -128 || sd > 127), (ud < 0), dd};
    endfunction

    // ---------------- transaction-level model ----------------
    // phase 0: waiting for operands, 1: computing, 2: holding result
    int           m_phase;
    int           m_left;
    logic [W+1:0] m_pend;
    logic [W-1:0] m_d;
    logic         m_bout;
    logic         m_ovf;
    logic         exp_in_ready;
    logic         exp_out_valid;

    // Model of the block's externally visible behaviour per clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase       <= 0;
            m_left        <= 0;
            m_d           <= '0;
            m_bout        <= 1'b0;
            m_ovf         <= 1'b0;
            exp_in_ready  <= 1'b1;
            exp_out_valid <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend       <= ref_sub(a, b, bin);
                    m_left       <= STEPS;
                    m_phase      <= 1;
                    exp_in_ready <= 1'b0;
                end
                1: if (m_left == 1) begin
                    {m_ovf, m_bout, m_d} <= m_pend;
                    m_phase       <= 2;
                    exp_out_valid <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) begin
                    m_phase       <= 0;
                    exp_out_valid <= 1'b0;
                    exp_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst && m_phase >= 0 && exp_in_ready !== 1'bx) begin
            chk("in_ready", 32'(in_ready), 32'(exp_in_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_out_valid));
            if (exp_out_valid) begin
                chk("d", 32'(d), 32'(m_d));
                chk("bout", 32'(bout), 32'(m_bout));
                chk("ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    // Issue one transaction, wait for the result and pin it to literals.
    // hold: cycles to keep out_ready low in DONE while poking in_valid.
    // rdy_hi: keep out_ready high for the whole transaction.
    task automatic do_txn(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tbin, input logic [7:0] ed, input logic eb,
                          input logic eo, input int hold, input logic rdy_hi);
        int cyc;
        chk({nm, "_in_ready_before"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = rdy_hi;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'h5A; b = 8'hC3; bin = 1'b1;
        chk({nm, "_accepted"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(STEPS));
        chk({nm, "_d"}, 32'(d), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        chk({nm, "_model_d"}, 32'(m_d), 32'(ed));
        chk({nm, "_model_flags"}, 32'({m_bout, m_ovf}), 32'({eb, eo}));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a = 8'hFF; b = 8'h00; bin = 1'b0;
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({nm, "_hold_d"}, 32'(d), 32'(ed));
            chk({nm, "_hold_flags"}, 32'({bout, ovf}), 32'({eb, eo}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_released"}, 32'(out_valid), 32'd0);
        chk({nm, "_kept_d"}, 32'(d), 32'(ed));
    endtask

    // Directed stimulus.
    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_d", 32'(d), 32'd0);
        chk("reset_flags", 32'({bout, ovf}), 32'd0);
        @(posedge clk); #1;

        do_txn("t1", 8'h35, 8'h13, 1'b0, 8'h22, 1'b0, 1'b0, 0, 1'b0);
        do_txn("t2", 8'h27, 8'h8F, 1'b1, 8'h97, 1'b1, 1'b1, 0, 1'b0);
        do_txn("t3a", 8'hE9, 8'hA0, 1'b0, 8'h49, 1'b0, 1'b0, 0, 1'b0);
        do_txn("t3b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
        do_txn("t4", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
        do_txn("t5", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 5, 1'b0);
        do_txn("rh1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b1);
        do_txn("rh2", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 0, 1'b1);
        do_txn("rh3", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 0, 1'b1);

        // Reset after slice 0 of an in-flight transaction.
        a = 8'hAB; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_d", 32'(d), 32'd0);
        chk("t6_flags", 32'({bout, ovf}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn("t6", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
